// File: rtl/pipe_pkg.sv
// Shared types for the generic inter-stage pipeline register.
package pipe_pkg;

    // Occupancy state of a stage register (held entries: 0, 1, 2)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_st_e;

    localparam int CNT_W = 2;

    // Sideband layouts that instantiating stages pack into i_ctrl (8 bits each)
    typedef struct packed {
        logic       rd_wren;
        logic [2:0] imm_sel;
        logic [3:0] alu_op;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       rd_wren;
        logic       mem_wren;
        logic [1:0] wb_sel;
        logic [1:0] byte_num;
        logic       mem_unsigned;
        logic       is_load;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic       rd_wren;
        logic [1:0] wb_sel;
        logic [4:0] rd_addr;
    } mem_wb_ctrl_t;

    // Number of held entries implied by a state
    function automatic logic [CNT_W-1:0] st_count(stage_st_e st);
        case (st)
            ST_ONE:  st_count = 2'd1;
            ST_TWO:  st_count = 2'd2;
            default: st_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One payload + sideband register with load enable. The sideband is always
// cleared on i_clr; the payload only when CLR_DATA is set, so wide data buses
// can be left static to save toggling.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 96,
    parameter int CTRL_W   = 8,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Next-value selection: clear beats load, otherwise hold
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (i_clr) begin
            ctrl_d = '0;
            if (CLR_DATA) begin
                data_d = '0;
            end
        end else if (i_load) begin
            data_d = i_data;
            ctrl_d = i_ctrl;
        end
    end

    // Slot storage
    always_ff @(posedge i_clk) begin
        data_q <= data_d;
        ctrl_q <= ctrl_d;
    end

    assign o_data = data_q;
    assign o_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid
// buffer. M is the head entry presented downstream; S catches the entry
// accepted in the cycle downstream stalls, so o_ready can be a flop.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 96,
    parameter int CTRL_W   = 8,
    parameter bit SKID_EN  = 1'b1,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_flushed,
    output logic [CNT_W-1:0]  o_count
);

    stage_st_e state_q, state_d;
    logic      ready_q, ready_d;
    logic      flushed_q, flushed_d;

    logic      accept, pop;
    logic      m_load, m_from_skid, s_load, slot_clr;

    logic [DATA_W-1:0] m_data, s_data, m_data_in;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;

    assign o_valid = (state_q != ST_EMPTY);
    assign o_ready = SKID_EN ? ready_q : (!o_valid || i_ready);
    assign accept  = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign slot_clr = i_reset || i_flush;

    // Next-state and slot load control; flush discards everything including
    // the same-cycle accept
    always_comb begin
        state_d     = state_q;
        m_load      = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_load  = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    if (SKID_EN) begin
                        s_load  = 1'b1;
                        state_d = ST_TWO;
                    end
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    m_load      = 1'b1;
                    m_from_skid = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (i_flush) begin
            state_d = ST_EMPTY;
            m_load  = 1'b0;
            s_load  = 1'b0;
        end
        ready_d   = (state_d != ST_TWO);
        flushed_d = i_flush;
    end

    // Control state; reset outranks flush
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_EMPTY;
            ready_q   <= 1'b1;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            flushed_q <= flushed_d;
        end
    end

    // Head register is refilled from the skid slot when draining TWO
    always_comb begin
        m_data_in = m_from_skid ? s_data : i_data;
        m_ctrl_in = m_from_skid ? s_ctrl : i_ctrl;
    end

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .i_clk  (i_clk),
        .i_clr  (slot_clr),
        .i_load (m_load),
        .i_data (m_data_in),
        .i_ctrl (m_ctrl_in),
        .o_data (m_data),
        .o_ctrl (m_ctrl)
    );

    if (SKID_EN) begin : g_skid
        pipe_slot #(
            .DATA_W   (DATA_W),
            .CTRL_W   (CTRL_W),
            .CLR_DATA (CLR_DATA)
        ) u_skid (
            .i_clk  (i_clk),
            .i_clr  (slot_clr),
            .i_load (s_load),
            .i_data (i_data),
            .i_ctrl (i_ctrl),
            .o_data (s_data),
            .o_ctrl (s_ctrl)
        );
    end else begin : g_no_skid
        assign s_data = '0;
        assign s_ctrl = '0;
    end

    assign o_data    = m_data;
    assign o_ctrl    = m_ctrl & {CTRL_W{o_valid}};
    assign o_flushed = flushed_q;
    assign o_count   = st_count(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Skid-buffered instance, data cleared on reset/flush
    logic        s_flush = 1'b0, s_valid = 1'b0, s_iready = 1'b0;
    logic [15:0] s_data = '0;
    logic [7:0]  s_ctrl = '0;
    logic        s_oready, s_ovalid, s_oflushed;
    logic [15:0] s_odata;
    logic [7:0]  s_octrl;
    logic [1:0]  s_count;

    pipe_stage_skid #(.DATA_W(16), .CTRL_W(8), .SKID_EN(1'b1), .CLR_DATA(1'b1)) dut (
        .i_clk(clk), .i_reset(rst), .i_flush(s_flush), .i_valid(s_valid),
        .o_ready(s_oready), .i_data(s_data), .i_ctrl(s_ctrl), .o_valid(s_ovalid),
        .i_ready(s_iready), .o_data(s_odata), .o_ctrl(s_octrl),
        .o_flushed(s_oflushed), .o_count(s_count)
    );

    // Single-register instance with combinational ready
    logic        n_flush = 1'b0, n_valid = 1'b0, n_iready = 1'b0;
    logic [15:0] n_data = '0;
    logic [7:0]  n_ctrl = '0;
    logic        n_oready, n_ovalid, n_oflushed;
    logic [15:0] n_odata;
    logic [7:0]  n_octrl;
    logic [1:0]  n_count;

    pipe_stage_skid #(.DATA_W(16), .CTRL_W(8), .SKID_EN(1'b0), .CLR_DATA(1'b0)) dut_ns (
        .i_clk(clk), .i_reset(rst), .i_flush(n_flush), .i_valid(n_valid),
        .o_ready(n_oready), .i_data(n_data), .i_ctrl(n_ctrl), .o_valid(n_ovalid),
        .i_ready(n_iready), .o_data(n_odata), .o_ctrl(n_octrl),
        .o_flushed(n_oflushed), .o_count(n_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_ctrl = 8'hFF;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", s_ovalid); end
        checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", s_count); end
        checks++; if (s_oflushed !== 1'b0) begin errors++; $display("FAIL reset_flushed got %0h exp 0", s_oflushed); end
        checks++; if (s_octrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %0h exp 0", s_octrl); end
        checks++; if (s_odata !== 16'h0000) begin errors++; $display("FAIL reset_data got %0h exp 0", s_odata); end
        checks++; if (s_oready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", s_oready); end
        checks++; if (n_count !== 2'd0) begin errors++; $display("FAIL reset_ns_count got %0d exp 0", n_count); end
    endtask

    task automatic test_stream();
        s_iready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            s_valid = 1'b1;
            s_data  = 16'(k);
            s_ctrl  = 8'(8'h10 + k);
            step();
            checks++; if (s_ovalid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h exp 1", k, s_ovalid); end
            checks++; if (s_odata !== 16'(k)) begin errors++; $display("FAIL stream_data[%0d] got %0h exp %0h", k, s_odata, k); end
            checks++; if (s_octrl !== 8'(8'h10 + k)) begin errors++; $display("FAIL stream_ctrl[%0d] got %0h exp %0h", k, s_octrl, 8'h10 + k); end
            checks++; if (s_count !== 2'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", k, s_count); end
        end
        s_valid = 1'b0;
        step();
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %0h exp 0", s_ovalid); end
        checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL stream_drain_count got %0d exp 0", s_count); end
    endtask

    task automatic test_backpressure();
        s_iready = 1'b1; s_valid = 1'b1; s_data = 16'h000A; s_ctrl = 8'h0A;
        step();
        s_iready = 1'b0; s_data = 16'h000B; s_ctrl = 8'h0B;
        #1;
        checks++; if (s_oready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %0h exp 1", s_oready); end
        step();
        checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL bp_count_two got %0d exp 2", s_count); end
        checks++; if (s_oready !== 1'b0) begin errors++; $display("FAIL bp_ready_two got %0h exp 0", s_oready); end
        checks++; if (s_odata !== 16'h000A) begin errors++; $display("FAIL bp_head_a got %0h exp a", s_odata); end
        s_data = 16'h000C; s_ctrl = 8'h0C;
        step();
        checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL bp_hold_count got %0d exp 2", s_count); end
        checks++; if (s_odata !== 16'h000A) begin errors++; $display("FAIL bp_hold_a got %0h exp a", s_odata); end
        checks++; if (s_octrl !== 8'h0A) begin errors++; $display("FAIL bp_hold_ctrl got %0h exp a", s_octrl); end
        s_iready = 1'b1;
        step();
        checks++; if (s_odata !== 16'h000B) begin errors++; $display("FAIL bp_pop_b got %0h exp b", s_odata); end
        checks++; if (s_count !== 2'd1) begin errors++; $display("FAIL bp_pop_b_count got %0d exp 1", s_count); end
        step();
        checks++; if (s_odata !== 16'h000C) begin errors++; $display("FAIL bp_pop_c got %0h exp c", s_odata); end
        checks++; if (s_count !== 2'd1) begin errors++; $display("FAIL bp_pop_c_count got %0d exp 1", s_count); end
        s_valid = 1'b0;
        step();
        checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL bp_empty_count got %0d exp 0", s_count); end
    endtask

    task automatic test_flush();
        s_iready = 1'b0; s_valid = 1'b1; s_data = 16'h0011; s_ctrl = 8'h81;
        step();
        s_data = 16'h0012; s_ctrl = 8'h82;
        step();
        checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL fl_setup_count got %0d exp 2", s_count); end
        s_data = 16'h000D; s_ctrl = 8'h55; s_flush = 1'b1;
        step();
        s_flush = 1'b0; s_valid = 1'b0;
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0h exp 0", s_ovalid); end
        checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", s_count); end
        checks++; if (s_octrl !== 8'h00) begin errors++; $display("FAIL fl_ctrl got %0h exp 0", s_octrl); end
        checks++; if (s_oflushed !== 1'b1) begin errors++; $display("FAIL fl_pulse got %0h exp 1", s_oflushed); end
        checks++; if (s_odata !== 16'h0000) begin errors++; $display("FAIL fl_data_clr got %0h exp 0", s_odata); end
        s_iready = 1'b1;
        step();
        checks++; if (s_oflushed !== 1'b0) begin errors++; $display("FAIL fl_pulse_end got %0h exp 0", s_oflushed); end
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL fl_no_d got %0h exp 0", s_ovalid); end
        // flush while EMPTY with an accept in the same cycle, held for two cycles
        s_valid = 1'b1; s_data = 16'h000E; s_flush = 1'b1;
        step();
        checks++; if (s_oflushed !== 1'b1) begin errors++; $display("FAIL fl_empty_pulse got %0h exp 1", s_oflushed); end
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL fl_accept_drop got %0h exp 0", s_ovalid); end
        step();
        checks++; if (s_oflushed !== 1'b1) begin errors++; $display("FAIL fl_b2b_pulse got %0h exp 1", s_oflushed); end
        s_flush = 1'b0; s_valid = 1'b0;
        step();
        checks++; if (s_oflushed !== 1'b0) begin errors++; $display("FAIL fl_b2b_end got %0h exp 0", s_oflushed); end
        checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL fl_b2b_count got %0d exp 0", s_count); end
    endtask

    task automatic test_bubble();
        s_valid = 1'b0; s_ctrl = 8'hFF; s_data = 16'h1234;
        step();
        checks++; if (s_octrl !== 8'h00) begin errors++; $display("FAIL bubble_ctrl got %0h exp 0", s_octrl); end
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0h exp 0", s_ovalid); end
    endtask

    task automatic test_reset_mid();
        s_iready = 1'b0; s_valid = 1'b1; s_data = 16'h0031; s_ctrl = 8'h31;
        step();
        s_data = 16'h0032;
        step();
        checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL rm_setup_count got %0d exp 2", s_count); end
        rst = 1'b1; s_flush = 1'b1;
        step();
        rst = 1'b0; s_flush = 1'b0; s_valid = 1'b0;
        checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL rm_count got %0d exp 0", s_count); end
        checks++; if (s_ovalid !== 1'b0) begin errors++; $display("FAIL rm_valid got %0h exp 0", s_ovalid); end
        checks++; if (s_oflushed !== 1'b0) begin errors++; $display("FAIL rm_flushed got %0h exp 0", s_oflushed); end
        checks++; if (s_oready !== 1'b1) begin errors++; $display("FAIL rm_ready got %0h exp 1", s_oready); end
    endtask

    task automatic test_no_skid();
        n_iready = 1'b1; n_valid = 1'b1; n_data = 16'h0021; n_ctrl = 8'h21;
        step();
        checks++; if (n_ovalid !== 1'b1) begin errors++; $display("FAIL ns_valid got %0h exp 1", n_ovalid); end
        checks++; if (n_count !== 2'd1) begin errors++; $display("FAIL ns_count1 got %0d exp 1", n_count); end
        n_valid = 1'b0; n_iready = 1'b0;
        #1;
        checks++; if (n_oready !== 1'b0) begin errors++; $display("FAIL ns_ready_lo got %0h exp 0", n_oready); end
        n_iready = 1'b1;
        #1;
        checks++; if (n_oready !== 1'b1) begin errors++; $display("FAIL ns_ready_hi got %0h exp 1", n_oready); end
        n_iready = 1'b0; n_valid = 1'b1; n_data = 16'h0022; n_ctrl = 8'h22;
        step();
        checks++; if (n_odata !== 16'h0021) begin errors++; $display("FAIL ns_hold_data got %0h exp 21", n_odata); end
        checks++; if (n_count !== 2'd1) begin errors++; $display("FAIL ns_hold_count got %0d exp 1", n_count); end
        n_iready = 1'b1;
        step();
        checks++; if (n_odata !== 16'h0022) begin errors++; $display("FAIL ns_next_data got %0h exp 22", n_odata); end
        checks++; if (n_count !== 2'd1) begin errors++; $display("FAIL ns_next_count got %0d exp 1", n_count); end
        n_valid = 1'b0;
        step();
        checks++; if (n_count !== 2'd0) begin errors++; $display("FAIL ns_empty_count got %0d exp 0", n_count); end
        checks++; if (n_octrl !== 8'h00) begin errors++; $display("FAIL ns_bubble_ctrl got %0h exp 0", n_octrl); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        test_reset_mid();
        test_no_skid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
